// File: rtl/usb_pkg.sv
// Shared USB receive-side types: FSM state encoding, PID classes, error codes
// and PID constants, plus the PID-to-class mapping.
package usb_pkg;

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        RX_WAIT_PID = 3'd1,
        RX_PID_CHK  = 3'd2,
        RX_PAYLOAD  = 3'd3,
        RX_ERR      = 3'd4
    } rx_state_t;

    // The class is the PID's two low bits.
    typedef enum logic [1:0] {
        CLS_SPECIAL = 2'b00,
        CLS_TOKEN   = 2'b01,
        CLS_HSHK    = 2'b10,
        CLS_DATA    = 2'b11
    } pid_class_t;

    typedef enum logic [1:0] {
        ERR_PID     = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_UNSUP   = 2'b11
    } err_code_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    function automatic pid_class_t pid_class(input logic [3:0] pid);
        return pid_class_t'(pid[1:0]);
    endfunction

endpackage

// File: rtl/usb_rx_packet_ctrl.sv
// Receive-side packet sequencer: steps the SYNC/PID decoder, counts and forwards
// payload bytes, and reports packet completion or a coded error.
module usb_rx_packet_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_BYTES    = 66,
    parameter int BYTE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       byte_valid,
    input  logic [7:0] data_in,
    input  logic       eop,
    input  logic       is_sync,
    input  logic       pid_valid,
    input  logic [3:0] pid,
    output logic       prev_sync,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic [3:0] pkt_pid,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);
    localparam int TMO_W = $clog2(BYTE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(BYTE_TIMEOUT);

    localparam logic [2:0] S_IDLE     = RX_IDLE;
    localparam logic [2:0] S_WAIT_PID = RX_WAIT_PID;
    localparam logic [2:0] S_PID_CHK  = RX_PID_CHK;
    localparam logic [2:0] S_PAYLOAD  = RX_PAYLOAD;
    localparam logic [2:0] S_ERR      = RX_ERR;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    pid_class_t       cls_q, cls_d;
    logic [3:0]       pkt_pid_q, pkt_pid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_data_valid_q, rx_data_valid_d;
    logic             pkt_done_q, pkt_done_d;
    logic             pkt_err_q, pkt_err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic             tmo_hit;
    logic             overflow;
    logic [CNT_W-1:0] new_cnt;

    function automatic logic len_ok(input pid_class_t cls, input logic [CNT_W-1:0] n);
        case (cls)
            CLS_TOKEN: return n == CNT_W'(2);
            CLS_DATA:  return (n >= CNT_W'(2)) && (n <= CNT_MAX);
            CLS_HSHK:  return n == '0;
            default:   return 1'b0;
        endcase
    endfunction

    assign tmo_hit = (tmo_q == TMO_MAX);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cls_d           = cls_q;
        pkt_pid_d       = pkt_pid_q;
        rx_data_d       = rx_data_q;
        rx_data_valid_d = 1'b0;
        pkt_done_d      = 1'b0;
        pkt_err_d       = 1'b0;
        err_code_d      = err_code_q;
        overflow        = 1'b0;
        new_cnt         = cnt_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (is_sync) state_d = S_WAIT_PID;
            end
            S_WAIT_PID: begin
                if (byte_valid) begin
                    state_d = S_PID_CHK;
                end else if (eop) begin
                    state_d    = S_ERR;
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_LEN;
                end else if (tmo_hit) begin
                    state_d    = S_ERR;
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_PID_CHK: begin
                if (!pid_valid) begin
                    state_d    = S_ERR;
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_PID;
                end else begin
                    pkt_pid_d = pid;
                    cls_d     = pid_class(pid);
                    if (pid_class(pid) == CLS_SPECIAL) begin
                        state_d    = S_ERR;
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_UNSUP;
                    end else begin
                        state_d = S_PAYLOAD;
                        cnt_d   = '0;
                    end
                end
            end
            S_PAYLOAD: begin
                // A byte arriving with eop is counted before the length check.
                if (byte_valid) begin
                    if (cnt_q == CNT_MAX) begin
                        overflow = 1'b1;
                    end else begin
                        new_cnt         = cnt_q + CNT_W'(1);
                        rx_data_d       = data_in;
                        rx_data_valid_d = 1'b1;
                    end
                end
                cnt_d = new_cnt;
                if (overflow) begin
                    state_d    = eop ? S_IDLE : S_ERR;
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_LEN;
                end else if (eop) begin
                    state_d = S_IDLE;
                    if (len_ok(cls_q, new_cnt)) begin
                        pkt_done_d = 1'b1;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                    end
                end else if (!byte_valid && tmo_hit) begin
                    state_d    = S_ERR;
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_ERR: begin
                if (eop || tmo_hit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Idle-cycle counter restarts on any line activity or state change and saturates.
    always_comb begin
        tmo_d = tmo_q;
        if ((state_q == S_IDLE) || byte_valid || eop || (state_d != state_q)) begin
            tmo_d = '0;
        end else if (!tmo_hit) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            tmo_q           <= '0;
            cls_q           <= CLS_SPECIAL;
            pkt_pid_q       <= 4'h0;
            rx_data_q       <= 8'h00;
            rx_data_valid_q <= 1'b0;
            pkt_done_q      <= 1'b0;
            pkt_err_q       <= 1'b0;
            err_code_q      <= 2'b00;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            tmo_q           <= tmo_d;
            cls_q           <= cls_d;
            pkt_pid_q       <= pkt_pid_d;
            rx_data_q       <= rx_data_d;
            rx_data_valid_q <= rx_data_valid_d;
            pkt_done_q      <= pkt_done_d;
            pkt_err_q       <= pkt_err_d;
            err_code_q      <= err_code_d;
        end
    end

    // The decoder needs prev_sync in the same cycle as the PID byte strobe.
    assign prev_sync     = (state_q == S_WAIT_PID);
    assign rx_active     = (state_q != S_IDLE);
    assign rx_data       = rx_data_q;
    assign rx_data_valid = rx_data_valid_q;
    assign pkt_pid       = pkt_pid_q;
    assign pkt_done      = pkt_done_q;
    assign pkt_err       = pkt_err_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Directed bench for usb_rx_packet_ctrl with a behavioural SYNC/PID decoder
// alongside; outputs are checked with immediate assertions.
module tb_usb_rx_packet_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] data_in;
    logic       eop;
    logic       is_sync;
    logic       pid_valid;
    logic [3:0] pid;
    logic       prev_sync;
    logic       rx_active;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic [3:0] pkt_pid;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;

    int vectors = 0;
    int miscompares = 0;

    int n_strobe = 0;
    int n_done = 0;
    int n_err = 0;
    logic [7:0] got[$];

    always #5 clk = ~clk;

    usb_rx_packet_ctrl dut (
        .clk          (clk),
        .RST          (rst),
        .byte_valid   (byte_valid),
        .data_in      (data_in),
        .eop          (eop),
        .is_sync      (is_sync),
        .pid_valid    (pid_valid),
        .pid          (pid),
        .prev_sync    (prev_sync),
        .rx_active    (rx_active),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .pkt_pid      (pkt_pid),
        .pkt_done     (pkt_done),
        .pkt_err      (pkt_err),
        .err_code     (err_code)
    );

    // Decoder model: registered SYNC detect and PID complement check.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            is_sync   <= 1'b0;
            pid_valid <= 1'b0;
            pid       <= 4'h0;
        end else begin
            is_sync   <= byte_valid && (data_in == 8'h80);
            pid_valid <= byte_valid && prev_sync && (data_in[7:4] == ~data_in[3:0]);
            pid       <= data_in[3:0];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_data_valid) begin
                n_strobe <= n_strobe + 1;
                got.push_back(rx_data);
            end
            if (pkt_done) n_done <= n_done + 1;
            if (pkt_err)  n_err  <= n_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic bv, input logic [7:0] d, input logic e);
        byte_valid = bv;
        data_in    = d;
        eop        = e;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        eop        = 1'b0;
    endtask

    // Leaves the DUT two cycles past the PID byte (PAYLOAD on a good PID).
    task automatic start_pkt(input string tag, input logic [7:0] pid_byte);
        drive(1'b1, 8'h80, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        chk({tag, "_prev_sync"}, prev_sync, 1);
        drive(1'b1, pid_byte, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int s0, d0, e0, b0, waited;
        rst        = 1'b1;
        byte_valid = 1'b0;
        data_in    = 8'h00;
        eop        = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_rx_active", rx_active, 0);
        chk("rst_prev_sync", prev_sync, 0);
        chk("rst_pkt_pid", pkt_pid, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_pkt_err", pkt_err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_rx_data", {rx_data_valid, rx_data}, 0);
        @(posedge clk); #1;

        // IN token
        s0 = n_strobe; d0 = n_done; e0 = n_err; b0 = got.size();
        start_pkt("in", 8'h69);
        chk("in_active", rx_active, 1);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk("in_done_latency", pkt_done, 1);
        idle(3);
        chk("in_pkt_pid", pkt_pid, 4'b1001);
        chk("in_strobes", n_strobe - s0, 2);
        chk("in_byte0", got[b0], 8'h11);
        chk("in_byte1", got[b0+1], 8'h22);
        chk("in_done", n_done - d0, 1);
        chk("in_err", n_err - e0, 0);
        chk("in_idle", rx_active, 0);

        // DATA0, 4 payload + 2 CRC, separate eop
        s0 = n_strobe; d0 = n_done; e0 = n_err; b0 = got.size();
        start_pkt("d0", 8'hC3);
        for (int i = 0; i < 6; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk("d0_done_latency", pkt_done, 1);
        idle(3);
        chk("d0_strobes", n_strobe - s0, 6);
        for (int i = 0; i < 6; i++) chk("d0_byte", got[b0+i], 8'hA0 + 8'(i));
        chk("d0_done", n_done - d0, 1);
        chk("d0_err", n_err - e0, 0);
        chk("d0_pkt_pid", pkt_pid, 4'b0011);

        // DATA0 with last byte and eop together
        s0 = n_strobe; d0 = n_done; e0 = n_err;
        start_pkt("d0s", 8'hC3);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'hB0 + 8'(i), 1'b0);
        drive(1'b1, 8'hB5, 1'b1);
        chk("d0s_done_latency", pkt_done, 1);
        chk("d0s_last_byte", rx_data, 8'hB5);
        idle(3);
        chk("d0s_strobes", n_strobe - s0, 6);
        chk("d0s_done", n_done - d0, 1);
        chk("d0s_err", n_err - e0, 0);

        // Bad PID
        s0 = n_strobe; e0 = n_err;
        start_pkt("bad", 8'h55);
        chk("bad_err_pulse", pkt_err, 1);
        chk("bad_err_code", err_code, 2'b00);
        idle(2);
        chk("bad_held_active", rx_active, 1);
        drive(1'b0, 8'h00, 1'b1);
        #1;
        chk("bad_idle", rx_active, 0);
        idle(2);
        chk("bad_strobes", n_strobe - s0, 0);
        chk("bad_single_err", n_err - e0, 1);

        // ACK with one stray byte
        d0 = n_done;
        start_pkt("ack", 8'hD2);
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk("ack_err_pulse", pkt_err, 1);
        chk("ack_err_code", err_code, 2'b01);
        chk("ack_pkt_pid", pkt_pid, 4'b0010);
        idle(2);
        chk("ack_no_done", n_done - d0, 0);

        // Token with three bytes
        start_pkt("tok3", 8'h69);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk("tok3_err_pulse", pkt_err, 1);
        chk("tok3_err_code", err_code, 2'b01);
        idle(2);

        // DATA1 overflow: 67 bytes
        s0 = n_strobe; e0 = n_err;
        start_pkt("ovf", 8'h4B);
        for (int i = 0; i < 67; i++) drive(1'b1, 8'(i + 1), 1'b0);
        chk("ovf_err_pulse", pkt_err, 1);
        chk("ovf_err_code", err_code, 2'b01);
        idle(2);
        chk("ovf_strobes", n_strobe - s0, 66);
        chk("ovf_last_fwd", got[got.size()-1], 8'd66);
        drive(1'b0, 8'h00, 1'b1);
        idle(1);
        chk("ovf_idle", rx_active, 0);
        chk("ovf_single_err", n_err - e0, 1);

        // Stall after PID
        start_pkt("tmo", 8'hC3);
        waited = 0;
        while (!pkt_err && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("tmo_err_pulse", pkt_err, 1);
        chk("tmo_err_code", err_code, 2'b10);
        chk("tmo_cycles", waited, 65);
        idle(70);
        chk("tmo_idle", rx_active, 0);

        // Reset mid-payload
        e0 = n_err;
        start_pkt("rst", 8'hC3);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_active", rx_active, 0);
        chk("rst_mid_valid", rx_data_valid, 0);
        chk("rst_mid_data", rx_data, 0);
        chk("rst_mid_pid", pkt_pid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        chk("rst_mid_no_err", n_err - e0, 0);
        d0 = n_done;
        start_pkt("post", 8'h69);
        drive(1'b1, 8'h44, 1'b0);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk("post_done_latency", pkt_done, 1);
        idle(2);
        chk("post_done", n_done - d0, 1);
        chk("post_pkt_pid", pkt_pid, 4'b1001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
